// File: rtl/nandy_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, PC width
// and the address the sequencer restarts from after reset.
package nandy_pkg;

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] RESET_VEC = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC0 = 2'b01,
    EXEC1 = 2'b10
  } state_t;

endpackage

// File: rtl/pc_incr.sv
// PC incrementer built as a ripple of half adders, matching the
// gate-level style of the rest of the machine. The carry out of the top
// bit is dropped so 0xFFFF wraps to 0x0000.
module pc_incr
  import nandy_pkg::*;
(
  input  logic [PC_W-1:0] a,
  output logic [PC_W-1:0] sum
);

  logic [PC_W-1:0] chain;

  assign chain[0] = 1'b1;

  for (genvar i = 0; i < PC_W; i++) begin : g_ha
    assign sum[i] = a[i] ^ chain[i];
    if (i < PC_W - 1) begin : g_carry
      assign chain[i+1] = a[i] & chain[i];
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: fetches one instruction byte per instruction,
// then runs one or two execute cycles (two when inst[7] is set). It owns
// the PC, the instruction register and the carry flag.
module fetch_sequencer
  import nandy_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [7:0]      inst,
  output logic            cycle,
  output logic            exec,
  output logic            carry,
  input  logic            carry_in,
  input  logic            wc_en,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_target,
  input  logic            mem_stall,
  output logic [PC_W-1:0] pc_link
);

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus1;
  logic            fetch_done;
  logic            exec_commit;

  pc_incr u_pc_incr (
    .a   (pc),
    .sum (pc_plus1)
  );

  // A fetch completes when memory acknowledges in FETCH; execute-side
  // strobes only act in EXEC0 or in an EXEC1 cycle that is not stalled.
  assign fetch_done  = (state == FETCH) && imem_ack;
  assign exec_commit = (state == EXEC0) || ((state == EXEC1) && !mem_stall);

  assign imem_addr = pc;
  assign pc_link   = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state logic: long instructions take EXEC1, which stalls on memory.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   state_next = imem_ack ? EXEC0 : FETCH;
      EXEC0:   state_next = inst[7] ? EXEC1 : FETCH;
      EXEC1:   state_next = mem_stall ? EXEC1 : FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    imem_req = 1'b0;
    exec     = 1'b0;
    cycle    = 1'b0;
    case (state)
      FETCH:   imem_req = 1'b1;
      EXEC0:   exec     = 1'b1;
      EXEC1: begin
        exec  = 1'b1;
        cycle = 1'b1;
      end
      default: imem_req = 1'b1;
    endcase
  end

  // PC: advance on a completed fetch, load the jump target on a committed jump.
  always_ff @(posedge clk) begin
    if (rst)                         pc <= RESET_VEC;
    else if (fetch_done)             pc <= pc_plus1;
    else if (exec_commit && jump_en) pc <= jump_target;
  end

  // Instruction register captures the fetched byte.
  always_ff @(posedge clk) begin
    if (rst)             inst <= 8'h00;
    else if (fetch_done) inst <= imem_data;
  end

  // Carry flag takes the ALU carry on a committed write-carry strobe.
  always_ff @(posedge clk) begin
    if (rst)                       carry <= 1'b0;
    else if (exec_commit && wc_en) carry <= carry_in;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL use one clock, clk; all state updates occur on its rising edge.
REQ-002 The block SHALL use reset rst, which is synchronous and active-high.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 imem_req  output  1  instruction-fetch request, high only in FETCH.
REQ-006 imem_addr  output  16  fetch address; equals pc.
REQ-007 imem_ack  input  1  fetch data valid this cycle.
REQ-008 imem_data  input  8  fetched instruction byte.
REQ-009 inst  output  8  instruction register, feeds the control decoder.
REQ-010 cycle  output  1  0 in the first execute cycle, 1 in the second.
REQ-011 exec  output  1  high in EXEC0 or EXEC1; decoder outputs are valid only then.
REQ-012 carry  output  1  carry flag register.
REQ-013 carry_in  input  1  new carry from ALU.
REQ-014 wc_en  input  1  write-carry strobe from decoder.
REQ-015 jump_en  input  1  jump strobe (decoder J or LJ).
REQ-016 jump_target  input  16  jump destination.
REQ-017 mem_stall  input  1  data memory busy; holds EXEC1.
REQ-018 pc_link  output  16  address of the next sequential instruction (pc), for link-jump save.

Function
REQ-019 The FSM SHALL have states FETCH, EXEC0 and EXEC1.
REQ-020 In FETCH with imem_ack=0: hold state; pc and inst unchanged; imem_req=1.
REQ-021 In FETCH with imem_ack=1: inst<=imem_data; pc<=pc+1 (mod 2^16, 0xFFFF wraps to 0x0000); next state EXEC0.
REQ-022 In EXEC0, if inst[7]=1, the next state SHALL be EXEC1; otherwise it SHALL be FETCH.
REQ-023 In EXEC1, if mem_stall=1, the FSM SHALL hold EXEC1; otherwise the next state SHALL be FETCH.
REQ-024 cycle SHALL be 1 only in EXEC1; exec SHALL be 1 in EXEC0 and EXEC1.
REQ-025 imem_req SHALL be 1 only in FETCH.
REQ-026 In EXEC0/EXEC1, jump_en=1 SHALL load pc<=jump_target at the clock edge; the state transition is unaffected.
REQ-027 In EXEC1 with mem_stall=1, jump_en SHALL be ignored; the jump is taken on the releasing cycle if still asserted.
REQ-028 jump_en and wc_en in FETCH SHALL be ignored.
REQ-029 wc_en=1 in EXEC0/EXEC1 SHALL set carry<=carry_in.
REQ-030 wc_en=1 in EXEC1 with mem_stall=1 SHALL be ignored.
REQ-031 Simultaneous wc_en and jump_en SHALL both take effect.
REQ-032 pc_link SHALL equal the current pc, combinationally.
REQ-033 Fetch latency SHALL be 1 cycle from imem_ack to exec=1.
REQ-034 Minimum instruction period SHALL be 2 cycles for inst[7]=0 and 3 cycles for inst[7]=1, excluding wait states.

Reset
REQ-035 When rst=1, the block SHALL set state=FETCH, pc=0x0000, inst=0x00 and carry=0 at the next edge.
REQ-036 During rst=1, outputs SHALL be imem_req=1, cycle=0, exec=0 after that edge.
REQ-037 rst SHALL take priority over imem_ack, jump_en, wc_en and mem_stall.
REQ-038 A reset mid-fetch or mid-execute SHALL abandon the operation with no pc or carry update.

Structure
REQ-039 Package nandy_pkg SHALL hold the state encoding (FETCH=2'b00, EXEC0=2'b01, EXEC1=2'b10), PC_W=16 and RESET_VEC=16'h0000.
REQ-040 The 16-bit incrementer SHALL be the sub-module pc_incr (a half-adder ripple, consistent with the gate-level style).
REQ-041 All other logic SHALL be in fetch_sequencer.

Verification
REQ-042 Reset, then imem_ack=1 with data 0x12 -> inst=0x12, pc=0x0001, exec=1, cycle=0 for one cycle, then imem_req=1.
REQ-043 Fetch 0xA5 (inst[7]=1) -> EXEC0 (cycle=0) then EXEC1 (cycle=1); hold mem_stall=1 for 3 cycles -> cycle stays 1 and pc unchanged; release -> FETCH.
REQ-044 Fetch 0xF0 at pc=0x0010, jump_en=1 in EXEC1 with jump_target=0x1234 -> next imem_addr=0x1234; pc_link read 0x0011 before the jump.
REQ-045 pc=0xFFFF, fetch with imem_ack=1 -> pc=0x0000.
REQ-046 imem_ack=0 for 5 cycles -> imem_req held, inst unchanged; wc_en/jump_en pulses during FETCH -> carry and pc unchanged.
REQ-047 Assert rst in EXEC1 with jump_en=1, wc_en=1 and carry_in=1 -> pc=0x0000, carry=0, state FETCH.
